// File: rtl/iob_native_mem_resp.sv
// Responder end of the IOb native bus: one initiator port served by a word-organised
// single-port memory, answering every request after WAIT_STATES extra cycles.
module iob_native_mem_resp #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_avalid,
    input  logic [ADDR_W-1:0]   req_address,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_rvalid,
    output logic                err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << MEM_ADDR_W;
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MEM_ADDR_W-1:0] idx_q, idx_d;
    logic                  in_range_q, in_range_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     mem_dout_q;
    logic                  is_read;
    logic [DATA_W-1:0]     rd_sel;
    logic                  unused_addr_bits;

    // The two byte-offset bits never select anything in a word memory.
    assign unused_addr_bits = ^req_address[1:0];

    assign is_read = (wstrb_q == '0);
    assign rd_sel  = in_range_q ? mem_dout_q : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_avalid) begin
                    idx_d      = req_address[MEM_ADDR_W+1:2];
                    in_range_d = (req_address[ADDR_W-1:MEM_ADDR_W+2] == '0);
                    wdata_d    = req_wdata;
                    wstrb_d    = req_wstrb;
                    cnt_d      = WS_CNT;
                    state_d    = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rvalid_d = 1'b1;
                if (!in_range_q) begin
                    err_d = 1'b1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                // Memory output register holds the ACCESS-cycle read; keep it for later cycles.
                if (is_read) begin
                    rdata_d = rd_sel;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Block-RAM style port: byte-enabled synchronous write, registered read, no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS) begin
            if (!is_read && in_range_q) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (wstrb_q[i]) begin
                        mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                end
            end
            if (is_read) begin
                mem_dout_q <= mem[idx_q];
            end
        end
    end

    assign resp_rdata  = (state_q == S_RESP && is_read) ? rd_sel : rdata_q;
    assign resp_rvalid = rvalid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_iob_native_mem_resp.sv
// Bench for iob_native_mem_resp: three instances (0, 3 and 4 wait states) checked every
// cycle against a transaction-level memory model, plus literal spot checks.
module tb_iob_native_mem_resp;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] rdata;
        bit          oor;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ws[3] = '{0, 3, 4};

    logic        clk = 1'b0;
    logic        rst    [3];
    logic        valid  [3];
    logic        nomask [3];
    logic        avalid [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [3:0]  wstrb  [3];
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        err    [3];

    exp_t        exp_q[$];
    logic [31:0] mdl_mem [int];
    logic [31:0] mdl_last [3];
    bit          mdl_err  [3];
    int          pulses   [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // picorv32-style masking unless a test deliberately holds avalid through rvalid
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            avalid[i] = valid[i] & (nomask[i] | ~rvalid[i]);
        end
    end

    iob_native_mem_resp #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst[0]), .req_avalid(avalid[0]), .req_address(addr[0]),
        .req_wdata(wdata[0]), .req_wstrb(wstrb[0]), .resp_rdata(rdata[0]),
        .resp_rvalid(rvalid[0]), .err(err[0])
    );
    iob_native_mem_resp #(.WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst[1]), .req_avalid(avalid[1]), .req_address(addr[1]),
        .req_wdata(wdata[1]), .req_wstrb(wstrb[1]), .resp_rdata(rdata[1]),
        .resp_rvalid(rvalid[1]), .err(err[1])
    );
    iob_native_mem_resp #(.WAIT_STATES(4)) dut2 (
        .clk(clk), .rst(rst[2]), .req_avalid(avalid[2]), .req_address(addr[2]),
        .req_wdata(wdata[2]), .req_wstrb(wstrb[2]), .resp_rdata(rdata[2]),
        .resp_rvalid(rvalid[2]), .err(err[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Scoreboard compare: every cycle, every instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int hit;
            hit = -1;
            for (int j = exp_q.size() - 1; j >= 0; j--) begin
                if (exp_q[j].inst == i && exp_q[j].cyc < cyc) exp_q.delete(j);
            end
            for (int j = 0; j < exp_q.size(); j++) begin
                if (exp_q[j].inst == i && exp_q[j].cyc == cyc) hit = j;
            end
            if (hit >= 0 && exp_q[hit].oor) mdl_err[i] = 1'b1;
            chk($sformatf("rvalid%0d@%0d", i, cyc), {31'b0, rvalid[i]},
                (hit >= 0) ? 32'd1 : 32'd0);
            if (hit >= 0) begin
                chk($sformatf("rdata%0d@%0d", i, cyc), rdata[i], exp_q[hit].rdata);
                exp_q.delete(hit);
            end
            chk($sformatf("err%0d@%0d", i, cyc), {31'b0, err[i]}, {31'b0, mdl_err[i]});
            if (rvalid[i] === 1'b1) pulses[i]++;
        end
    end

    // Called just after a rising edge with the instance idle.
    task automatic xfer(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold,
                        output logic [31:0] got, output int lat);
        exp_t        e;
        bit          inr;
        int          key;
        int          n;
        int          start;
        logic [31:0] w;
        inr = (a[31:12] == 20'd0);
        key = i * 4096 + int'(a[11:2]);
        if (s == 4'd0) begin
            e.rdata     = inr ? mdl_mem[key] : 32'd0;
            mdl_last[i] = e.rdata;
        end else begin
            e.rdata = mdl_last[i];
            if (inr) begin
                w = mdl_mem.exists(key) ? mdl_mem[key] : 32'd0;
                for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
                mdl_mem[key] = w;
            end
        end
        e.inst = i;
        e.cyc  = cyc + 2 + ws[i];
        e.oor  = !inr;
        exp_q.push_back(e);
        start     = cyc;
        addr[i]   = a;
        wdata[i]  = d;
        wstrb[i]  = s;
        nomask[i] = hold;
        valid[i]  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rvalid[i] !== 1'b1 && n < 50);
        got = rdata[i];
        lat = cyc - start;
        if (rvalid[i] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout%0d: got no rvalid want rvalid within 50 cycles", i);
        end
        @(posedge clk);
        #1;
        valid[i]  = 1'b0;
        nomask[i] = 1'b0;
    endtask

    task automatic apply_reset(input int i);
        rst[i]      = 1'b1;
        valid[i]    = 1'b0;
        mdl_err[i]  = 1'b0;
        mdl_last[i] = 32'd0;
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].inst == i) exp_q.delete(j);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] bdata [16];
        int          lat;
        int          p0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; nomask[i] = 1'b0;
            addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
            mdl_last[i] = '0; mdl_err[i] = 1'b0; pulses[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_rdata%0d", i), rdata[i], 32'd0);
            chk($sformatf("reset_rvalid%0d", i), {31'b0, rvalid[i]}, 32'd0);
            chk($sformatf("reset_err%0d", i), {31'b0, err[i]}, 32'd0);
            rst[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Full-word round trip, zero wait states
        xfer(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, got, lat);
        chk("rt_wr_lat", lat, 32'd2);
        xfer(0, 32'h10, 32'h0, 4'h0, 0, got, lat);
        chk("rt_rd_lat", lat, 32'd2);
        chk("rt_rd_data", got, 32'hDEADBEEF);

        // Partial-strobe write
        xfer(0, 32'h20, 32'h11223344, 4'hF, 0, got, lat);
        xfer(0, 32'h20, 32'hAABBCCDD, 4'h5, 0, got, lat);
        chk("strb_wr_keeps_rdata", got, 32'hDEADBEEF);
        xfer(0, 32'h23, 32'h0, 4'h0, 0, got, lat);
        chk("strb_rd_data", got, 32'h11BB33DD);

        // Wait-state latency with avalid held through the response
        p0 = pulses[1];
        xfer(1, 32'h40, 32'h0BADF00D, 4'hF, 1, got, lat);
        chk("ws3_wr_lat", lat, 32'd5);
        xfer(1, 32'h40, 32'h0, 4'h0, 1, got, lat);
        chk("ws3_rd_lat", lat, 32'd5);
        chk("ws3_rd_data", got, 32'h0BADF00D);
        repeat (8) @(posedge clk);
        #1;
        chk("ws3_pulses", pulses[1] - p0, 32'd2);

        // Out-of-range access
        xfer(0, 32'h0, 32'hCAFEF00D, 4'hF, 0, got, lat);
        chk("oor_err_before", {31'b0, err[0]}, 32'd0);
        xfer(0, 32'h1000, 32'h12345678, 4'hF, 0, got, lat);
        chk("oor_wr_lat", lat, 32'd2);
        chk("oor_err_set", {31'b0, err[0]}, 32'd1);
        xfer(0, 32'h1000, 32'h0, 4'h0, 0, got, lat);
        chk("oor_rd_data", got, 32'd0);
        xfer(0, 32'h0, 32'h0, 4'h0, 0, got, lat);
        chk("oor_word0_kept", got, 32'hCAFEF00D);
        chk("oor_err_sticky", {31'b0, err[0]}, 32'd1);

        // Back-to-back burst: 16 writes then 16 reads
        p0 = pulses[0];
        for (int k = 0; k < 16; k++) begin
            bdata[k] = $urandom;
            xfer(0, 32'h100 + 32'(4 * k), bdata[k], 4'hF, 0, got, lat);
        end
        for (int k = 0; k < 16; k++) begin
            xfer(0, 32'h100 + 32'(4 * k), 32'h0, 4'h0, 0, got, lat);
            chk($sformatf("burst_rd%0d", k), got, bdata[k]);
        end
        chk("burst_pulses", pulses[0] - p0, 32'd32);

        // Reset in the middle of a wait phase
        xfer(2, 32'h2000, 32'h55, 4'hF, 0, got, lat);
        chk("ws4_err_set", {31'b0, err[2]}, 32'd1);
        addr[2] = 32'h40; wdata[2] = 32'h0; wstrb[2] = 4'h0; valid[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        apply_reset(2);
        #1;
        chk("midrst_rvalid", {31'b0, rvalid[2]}, 32'd0);
        chk("midrst_err", {31'b0, err[2]}, 32'd0);
        chk("midrst_rdata", rdata[2], 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst[2] = 1'b0;
        xfer(2, 32'h44, 32'hABCD0123, 4'hF, 0, got, lat);
        chk("after_rst_wr_lat", lat, 32'd6);
        xfer(2, 32'h44, 32'h0, 4'h0, 0, got, lat);
        chk("after_rst_rd_lat", lat, 32'd6);
        chk("after_rst_rd_data", got, 32'hABCD0123);

        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
